imu_spi_seq: RTL and testbench
==============================

# imu_spi_seq

SPI transaction sequencer for the flight controller's inertial sensor. Sits between the SPI monarch and the attitude integrator. After reset it programs the sensor's configuration registers. On each sensor data-ready interrupt it then reads six rate bytes and presents signed 16-bit pitch/roll/yaw rates with a one-cycle valid strobe. It is the only block that drives the monarch's `spi_write_en`/`wt_data`.

## Interface
- `INIT_WAIT`, default 16'hFFFF: cycles after reset release before the first config write (sensor power-up).
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `INT`  in  1  sensor data-ready; asynchronous to `clk`.
- `spi_done`  in  1  monarch done level; cleared by the monarch when a transaction starts.
- `rd_data`  in  16  monarch read word; the byte of interest is `[7:0]`.
- `spi_write_en`  out  1  one-cycle transaction start pulse to the monarch.
- `wt_data`  out  16  command word, held stable from the `spi_write_en` cycle until completion.
- `init_done`  out  1  high once all config writes have completed; stays high until reset.
- `ptch_rt`, `roll_rt`, `yaw_rt`  out  16 each  signed rates, `{high byte, low byte}`.
- `vld`  out  1  one-cycle pulse when all three rates have been updated.

## Operation
- Config table, in order: `16'h0D02`, `16'h1053`, `16'h1150`, `16'h1460`.
- Read commands are `{1'b1, addr[6:0], 8'h00}`, with addresses in order `A2, A3, A4, A5, A6, A7`.
  - Bytes land as: pitch low, pitch high, roll low, roll high, yaw low, yaw high.
- States:
  - **PWR_WAIT**: count `INIT_WAIT` cycles, then go to CFG_ISSUE.
  - **CFG_ISSUE**: pulse `spi_write_en` with `wt_data = cfg[idx]`, then go to CFG_WAIT.
  - **CFG_WAIT**: on completion, `idx++`. If `idx` was 3, set `init_done`, clear `idx`, go to IDLE; otherwise go to CFG_ISSUE.
  - **IDLE**: on `int_rise` or `pend`, clear `pend` and go to RD_ISSUE.
  - **RD_ISSUE**: pulse `spi_write_en` with the read command for `idx`, then go to RD_WAIT.
  - **RD_WAIT**: on completion, capture `rd_data[7:0]` into the byte slot for `idx`, then `idx++`. If `idx` was 5, go to DONE; otherwise go to RD_ISSUE.
  - **DONE**: pulse `vld`, clear `idx`, go to IDLE.
- Completion means a rising edge of `spi_done` (compare against a registered copy). A done level left over from the previous transaction is never treated as completion.
- `INT` passes through a two-flop synchronizer and then a rise detector to form `int_rise`. `INT` edges before `init_done` are ignored.
- A `int_rise` arriving outside IDLE (after `init_done`) sets `pend`. `pend` is one deep: further edges while it is set are dropped.
- `ptch_rt`/`roll_rt`/`yaw_rt` update only in DONE, all in the same cycle. Partial reads are never visible on these outputs.

## Timing
- Reset values:
  - `spi_write_en`=0, `wt_data`=0, `init_done`=0, all rates=0, `vld`=0.
  - `idx`=0, `pend`=0, state=PWR_WAIT, synchronizer flops=0.
- `spi_write_en` is high for exactly one cycle per transaction. It is never reasserted before completion is seen.
- `wt_data` is registered and valid in the same cycle as `spi_write_en`.
- INT pin rise to `int_rise`: 3 cycles. From `int_rise` in IDLE to the first `spi_write_en`: 2 cycles.
- `vld` rises 1 cycle after the sixth completion edge.
- The per-transaction gap after completion is 1 cycle (the ISSUE state).
- If `int_rise` and DONE occur in the same cycle, `pend` is set and is serviced on the next IDLE cycle.
- `rst` asserted mid-transaction forces reset values immediately. The in-flight monarch transaction is abandoned. After reset the block waits `INIT_WAIT` again and reprograms all config registers.

## Structure
- Package `imu_spi_seq_pkg` holds:
  - the state enum `seq_state_t`;
  - the `CFG_TBL[0:3]` constants;
  - the `RD_ADDR[0:5]` constants;
  - `RD_CMD_MSB`.
- Sub-module `int_sync`: two-flop synchronizer plus rise detect. Ports: `clk`, `rst`, `async_in`, `rise`.
- `idx` is a single shared 3-bit counter used for both the config and read phases.

## Test plan
- **Reset/config:** `INIT_WAIT`=8, monarch model returns done 40 cycles after each start. Expect four `spi_write_en` pulses carrying `0D02`, `1053`, `1150`, `1460` in order, then `init_done`=1, with no pulse before cycle 8.
- **Read frame:** model `rd_data[7:0]` returns `34,12,CD,AB,01,80`. Pulse `INT`. Expect commands `A200`…`A700`, then `vld` pulses once with `ptch_rt`=1234, `roll_rt`=ABCD, `yaw_rt`=8001.
- **Stale done:** hold `spi_done`=1 through IDLE and drop it 2 cycles after `spi_write_en`. Expect no early advance; only the following rising edge counts as completion.
- **Pending:** two `INT` edges during one frame. Expect exactly two frames and two `vld` pulses; the second frame's first `spi_write_en` arrives 2 cycles after the first `vld`.
- **Early INT:** `INT` toggled during PWR_WAIT/CFG. Expect no read commands issued and `pend`=0 at `init_done`.
- **Mid-op reset:** assert `rst` during the third read. Expect all outputs to go to zero immediately and the config sequence to repeat after `INIT_WAIT`.

Source files
------------

// File: rtl/imu_spi_seq_pkg.sv
// imu_spi_seq shared types and constants.
// Holds the sequencer state encoding, the sensor config table and the rate-register addresses.
package imu_spi_seq_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    CFG_ISSUE,
    CFG_WAIT,
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    DONE
  } seq_state_t;

  localparam logic [15:0] CFG_TBL [0:3] = '{
    16'h0D02, 16'h1053, 16'h1150, 16'h1460
  };

  // With the read MSB set, these form command bytes A2..A7.
  localparam logic [6:0] RD_ADDR [0:5] = '{
    7'h22, 7'h23, 7'h24, 7'h25, 7'h26, 7'h27
  };

  localparam logic RD_CMD_MSB = 1'b1;

  function automatic logic [15:0] rd_cmd(
    input logic [6:0] addr
  );
    return {RD_CMD_MSB, addr, 8'h00};
  endfunction

endpackage

// File: rtl/imu_spi_seq_if.sv
// SPI monarch command/response bundle.
// The sequencer is the master; the monarch is the slave side.
interface imu_spi_seq_if;
  logic        spi_write_en;
  logic [15:0] wt_data;
  logic        spi_done;
  logic [15:0] rd_data;

  modport master (
    output spi_write_en,
    output wt_data,
    input  spi_done,
    input  rd_data
  );

  modport slave (
    input  spi_write_en,
    input  wt_data,
    output spi_done,
    output rd_data
  );
endinterface

// File: rtl/imu_spi_seq_int_sync.sv
// Two-flop synchronizer for the sensor interrupt pin.
// Rise pulse is registered: pin rise to pulse is three cycles.
module int_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);
  logic s1;
  logic s2;
  logic s2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      s2_d <= s2;
      rise <= s2 & ~s2_d;
    end
  end
endmodule

// File: rtl/imu_spi_seq.sv
// IMU SPI sequencer: programs sensor config after power-up,
// then reads pitch/roll/yaw rates on each data-ready interrupt.
module imu_spi_seq
  import imu_spi_seq_pkg::*;
#(
  parameter logic [15:0] INIT_WAIT = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                INT,
  imu_spi_seq_if.master       spi,
  output logic                init_done,
  output logic [15:0]         ptch_rt,
  output logic [15:0]         roll_rt,
  output logic [15:0]         yaw_rt,
  output logic                vld
);

  seq_state_t  state;
  seq_state_t  state_nxt;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic        pend;
  logic        done_q;
  logic        comp;
  logic        int_rise;
  logic        cnt_hit;
  logic        last_cfg;
  logic        last_rd;
  logic        start_rd;
  logic [7:0]  rbuf [0:5];

  int_sync u_int_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (INT),
    .rise     (int_rise)
  );

  // Edge, not level: a done left high from the last transfer is stale.
  assign comp     = spi.spi_done & ~done_q;
  assign cnt_hit  = ({1'b0, cnt} + 17'd1) >= {1'b0, INIT_WAIT};
  assign last_cfg = (idx == 3'd3);
  assign last_rd  = (idx == 3'd5);
  assign start_rd = int_rise | pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PWR_WAIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      PWR_WAIT:  if (cnt_hit) state_nxt = CFG_ISSUE;
      CFG_ISSUE: state_nxt = CFG_WAIT;
      CFG_WAIT:
        if (comp) state_nxt = last_cfg ? IDLE : CFG_ISSUE;
      IDLE:      if (start_rd) state_nxt = RD_ISSUE;
      RD_ISSUE:  state_nxt = RD_WAIT;
      RD_WAIT:
        if (comp) state_nxt = last_rd ? DONE : RD_ISSUE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt              <= '0;
      idx              <= '0;
      pend             <= 1'b0;
      done_q           <= 1'b0;
      init_done        <= 1'b0;
      vld              <= 1'b0;
      ptch_rt          <= '0;
      roll_rt          <= '0;
      yaw_rt           <= '0;
      spi.spi_write_en <= 1'b0;
      spi.wt_data      <= '0;
      for (int i = 0; i < 6; i++) rbuf[i] <= '0;
    end else begin
      done_q           <= spi.spi_done;
      spi.spi_write_en <= 1'b0;
      vld              <= 1'b0;
      // Edges outside IDLE are held one deep; IDLE consumes them.
      if (init_done && int_rise && state != IDLE)
        pend <= 1'b1;
      unique case (state)
        PWR_WAIT: cnt <= cnt + 16'd1;
        CFG_ISSUE: begin
          spi.spi_write_en <= 1'b1;
          spi.wt_data      <= CFG_TBL[idx[1:0]];
        end
        CFG_WAIT: begin
          if (comp) begin
            idx <= last_cfg ? 3'd0 : idx + 3'd1;
            if (last_cfg) init_done <= 1'b1;
          end
        end
        IDLE: if (start_rd) pend <= 1'b0;
        RD_ISSUE: begin
          spi.spi_write_en <= 1'b1;
          spi.wt_data      <= rd_cmd(RD_ADDR[idx]);
        end
        RD_WAIT: begin
          if (comp) begin
            rbuf[idx] <= spi.rd_data[7:0];
            idx       <= idx + 3'd1;
          end
        end
        DONE: begin
          idx     <= '0;
          vld     <= 1'b1;
          ptch_rt <= {rbuf[1], rbuf[0]};
          roll_rt <= {rbuf[3], rbuf[2]};
          yaw_rt  <= {rbuf[5], rbuf[4]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imu_spi_seq.sv
// Directed bench for imu_spi_seq with a fixed-latency monarch model.
// Covers config, read frames, stale done, pending INT and mid-op reset.
module tb_imu_spi_seq;
  import imu_spi_seq_pkg::*;

  localparam int LAT = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        int_pin = 1'b0;
  logic        init_done;
  logic [15:0] ptch_rt;
  logic [15:0] roll_rt;
  logic [15:0] yaw_rt;
  logic        vld;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit busy = 0;
  bit stale_mode = 0;
  int lat_cnt = 0;
  logic [15:0] cur_cmd = '0;

  logic [15:0] we_log [$];
  int          we_cyc [$];
  int          vld_cyc [$];
  logic [15:0] p_log [$];
  logic [15:0] r_log [$];
  logic [15:0] y_log [$];

  logic [15:0] exp_cfg [0:3] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  logic [15:0] exp_rd  [0:5] = '{16'hA200, 16'hA300, 16'hA400,
                                 16'hA500, 16'hA600, 16'hA700};

  imu_spi_seq_if spi ();

  imu_spi_seq #(.INIT_WAIT(16'd8)) dut (
    .clk       (clk),
    .rst       (rst),
    .INT       (int_pin),
    .spi       (spi.master),
    .init_done (init_done),
    .ptch_rt   (ptch_rt),
    .roll_rt   (roll_rt),
    .yaw_rt    (yaw_rt),
    .vld       (vld)
  );

  always #10 clk = ~clk;

  function automatic logic [7:0] byte_for(input logic [15:0] cmd);
    case (cmd[15:8])
      8'hA2:   return 8'h34;
      8'hA3:   return 8'h12;
      8'hA4:   return 8'hCD;
      8'hA5:   return 8'hAB;
      8'hA6:   return 8'h01;
      8'hA7:   return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  // Monarch model and output monitor, all on the falling edge.
  initial begin
    spi.spi_done = 1'b0;
    spi.rd_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        busy         = 0;
        spi.spi_done = 1'b0;
      end else begin
        if (vld) begin
          vld_cyc.push_back(cyc);
          p_log.push_back(ptch_rt);
          r_log.push_back(roll_rt);
          y_log.push_back(yaw_rt);
        end
        if (spi.spi_write_en) begin
          checks++;
          if (busy) begin
            errors++;
            $display("FAIL we_while_busy cyc=%0d got=1 want=0", cyc);
          end
          we_log.push_back(spi.wt_data);
          we_cyc.push_back(cyc);
          cur_cmd = spi.wt_data;
          busy    = 1;
          lat_cnt = 0;
          if (!stale_mode) spi.spi_done = 1'b0;
        end else if (busy) begin
          lat_cnt++;
          if (stale_mode && lat_cnt == 2) spi.spi_done = 1'b0;
          if (lat_cnt == LAT) begin
            checks++;
            if (spi.wt_data !== cur_cmd) begin
              errors++;
              $display("FAIL wt_data_hold got=%h want=%h",
                       spi.wt_data, cur_cmd);
            end
            spi.rd_data  = {8'h00, byte_for(cur_cmd)};
            spi.spi_done = 1'b1;
            busy         = 0;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_int();
    int_pin = 1'b1;
    tick(4);
    int_pin = 1'b0;
  endtask

  task automatic wait_vld(input int n, input int bound, output bit ok);
    int t = 0;
    while (vld_cyc.size() < n && t < bound) begin
      tick(1);
      t++;
    end
    ok = (vld_cyc.size() >= n);
  endtask

  task automatic wait_we(input int n, input int bound, output bit ok);
    int t = 0;
    while (we_log.size() < n && t < bound) begin
      tick(1);
      t++;
    end
    ok = (we_log.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if (spi.spi_write_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_we got=%b want=0", spi.spi_write_en);
    end
    checks++;
    if (spi.wt_data !== 16'h0000) begin
      errors++;
      $display("FAIL rst_wt got=%h want=0000", spi.wt_data);
    end
    checks++;
    if (init_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_init got=%b want=0", init_done);
    end
    checks++;
    if ({ptch_rt, roll_rt, yaw_rt} !== 48'h0) begin
      errors++;
      $display("FAIL rst_rates got=%h want=0",
               {ptch_rt, roll_rt, yaw_rt});
    end
    checks++;
    if (vld !== 1'b0) begin
      errors++;
      $display("FAIL rst_vld got=%b want=0", vld);
    end
    checks++;
    if (dut.pend !== 1'b0 || dut.idx !== 3'd0) begin
      errors++;
      $display("FAIL rst_pend_idx got=%b/%0d want=0/0",
               dut.pend, dut.idx);
    end
  endtask

  // Releases reset, toggles INT during power-up and config, awaits init.
  task automatic test_config();
    int base;
    int rel;
    int n = 0;
    base = we_log.size();
    rst  = 1'b0;
    rel  = cyc;
    while (!init_done && n < 600) begin
      if (n == 2 || n == 60 || n == 120) int_pin = 1'b1;
      if (n == 6 || n == 66 || n == 126) int_pin = 1'b0;
      tick(1);
      n++;
    end
    int_pin = 1'b0;
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL cfg_init_done got=%b want=1", init_done);
    end
    checks++;
    if (we_log.size() - base != 4) begin
      errors++;
      $display("FAIL cfg_count got=%0d want=4", we_log.size() - base);
    end
    for (int i = 0; i < 4; i++) begin
      if (base + i < we_log.size()) begin
        checks++;
        if (we_log[base+i] !== exp_cfg[i]) begin
          errors++;
          $display("FAIL cfg_word%0d got=%h want=%h",
                   i, we_log[base+i], exp_cfg[i]);
        end
      end
    end
    if (base < we_log.size()) begin
      checks++;
      if (we_cyc[base] - rel < 8) begin
        errors++;
        $display("FAIL cfg_init_wait got=%0d want>=8",
                 we_cyc[base] - rel);
      end
    end
  endtask

  task automatic test_early_int();
    int base;
    base = we_log.size();
    checks++;
    if (dut.pend !== 1'b0) begin
      errors++;
      $display("FAIL early_pend got=%b want=0", dut.pend);
    end
    tick(60);
    checks++;
    if (we_log.size() != base) begin
      errors++;
      $display("FAIL early_reads got=%0d want=0", we_log.size() - base);
    end
    checks++;
    if (vld_cyc.size() != 0) begin
      errors++;
      $display("FAIL early_vld got=%0d want=0", vld_cyc.size());
    end
  endtask

  task automatic check_frame(input string nm, input int wb, input int vb);
    for (int i = 0; i < 6; i++) begin
      if (wb + i < we_log.size()) begin
        checks++;
        if (we_log[wb+i] !== exp_rd[i]) begin
          errors++;
          $display("FAIL %s_cmd%0d got=%h want=%h",
                   nm, i, we_log[wb+i], exp_rd[i]);
        end
      end
    end
    if (vb < vld_cyc.size()) begin
      checks++;
      if ({p_log[vb], r_log[vb], y_log[vb]} !== 48'h1234_ABCD_8001) begin
        errors++;
        $display("FAIL %s_rates got=%h/%h/%h want=1234/abcd/8001",
                 nm, p_log[vb], r_log[vb], y_log[vb]);
      end
    end
  endtask

  task automatic test_read_frame();
    int wb;
    int vb;
    int k;
    bit ok;
    wb = we_log.size();
    vb = vld_cyc.size();
    k  = cyc;
    pulse_int();
    wait_vld(vb + 1, 800, ok);
    tick(20);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rd_timeout got=%0d want=%0d", vld_cyc.size(), vb + 1);
    end
    checks++;
    if (we_log.size() - wb != 6) begin
      errors++;
      $display("FAIL rd_count got=%0d want=6", we_log.size() - wb);
    end
    checks++;
    if (vld_cyc.size() - vb != 1) begin
      errors++;
      $display("FAIL rd_vld_count got=%0d want=1", vld_cyc.size() - vb);
    end
    if (wb < we_log.size()) begin
      checks++;
      if (we_cyc[wb] - k != 5) begin
        errors++;
        $display("FAIL rd_int_latency got=%0d want=5", we_cyc[wb] - k);
      end
    end
    check_frame("rd", wb, vb);
  endtask

  task automatic test_stale_done();
    int wb;
    int vb;
    bit ok;
    wb = we_log.size();
    vb = vld_cyc.size();
    checks++;
    if (spi.spi_done !== 1'b1) begin
      errors++;
      $display("FAIL stale_setup got=%b want=1", spi.spi_done);
    end
    stale_mode = 1;
    pulse_int();
    wait_vld(vb + 1, 800, ok);
    tick(20);
    stale_mode = 0;
    checks++;
    if (!ok || we_log.size() - wb != 6) begin
      errors++;
      $display("FAIL stale_frame got=%0d want=6", we_log.size() - wb);
    end
    for (int i = 1; i < 6; i++) begin
      if (wb + i < we_cyc.size()) begin
        checks++;
        if (we_cyc[wb+i] - we_cyc[wb+i-1] < LAT) begin
          errors++;
          $display("FAIL stale_gap%0d got=%0d want>=%0d",
                   i, we_cyc[wb+i] - we_cyc[wb+i-1], LAT);
        end
      end
    end
    check_frame("stale", wb, vb);
  endtask

  task automatic test_pending();
    int wb;
    int vb;
    bit ok;
    wb = we_log.size();
    vb = vld_cyc.size();
    pulse_int();
    wait_we(wb + 2, 200, ok);
    tick(3);
    pulse_int();
    tick(10);
    pulse_int();
    wait_vld(vb + 2, 1600, ok);
    tick(400);
    checks++;
    if (vld_cyc.size() - vb != 2) begin
      errors++;
      $display("FAIL pend_vld_count got=%0d want=2", vld_cyc.size() - vb);
    end
    checks++;
    if (we_log.size() - wb != 12) begin
      errors++;
      $display("FAIL pend_cmd_count got=%0d want=12", we_log.size() - wb);
    end
    if (wb + 6 < we_cyc.size() && vb < vld_cyc.size()) begin
      checks++;
      if (we_cyc[wb+6] - vld_cyc[vb] != 2) begin
        errors++;
        $display("FAIL pend_restart got=%0d want=2",
                 we_cyc[wb+6] - vld_cyc[vb]);
      end
    end
    check_frame("pend1", wb, vb);
    check_frame("pend2", wb + 6, vb + 1);
  endtask

  task automatic test_mid_reset();
    int wb;
    int rel;
    int n = 0;
    bit ok;
    wb = we_log.size();
    pulse_int();
    wait_we(wb + 3, 300, ok);
    tick(5);
    rst = 1'b1;
    #1;
    checks++;
    if (!ok || spi.spi_write_en !== 1'b0 || spi.wt_data !== 16'h0) begin
      errors++;
      $display("FAIL mrst_spi got=%b/%h want=0/0000",
               spi.spi_write_en, spi.wt_data);
    end
    checks++;
    if ({ptch_rt, roll_rt, yaw_rt} !== 48'h0 || vld !== 1'b0) begin
      errors++;
      $display("FAIL mrst_rates got=%h/%b want=0/0",
               {ptch_rt, roll_rt, yaw_rt}, vld);
    end
    checks++;
    if (init_done !== 1'b0 || dut.state !== PWR_WAIT) begin
      errors++;
      $display("FAIL mrst_state got=%b/%0d want=0/%0d",
               init_done, dut.state, PWR_WAIT);
    end
    tick(3);
    wb  = we_log.size();
    rst = 1'b0;
    rel = cyc;
    while (!init_done && n < 600) begin
      tick(1);
      n++;
    end
    tick(20);
    checks++;
    if (we_log.size() - wb != 4) begin
      errors++;
      $display("FAIL mrst_cfg_count got=%0d want=4", we_log.size() - wb);
    end
    for (int i = 0; i < 4; i++) begin
      if (wb + i < we_log.size()) begin
        checks++;
        if (we_log[wb+i] !== exp_cfg[i]) begin
          errors++;
          $display("FAIL mrst_cfg%0d got=%h want=%h",
                   i, we_log[wb+i], exp_cfg[i]);
        end
      end
    end
    if (wb < we_cyc.size()) begin
      checks++;
      if (we_cyc[wb] - rel < 8) begin
        errors++;
        $display("FAIL mrst_wait got=%0d want>=8", we_cyc[wb] - rel);
      end
    end
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL mrst_init got=%b want=1", init_done);
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_early_int();
    test_read_frame();
    test_stale_done();
    test_pending();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
